// File: rtl/lockin_result_scheduler_pkg.sv
// Shared types and constants for the lock-in result scheduler.
package lockin_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      RUN,
      DRAIN,
      DONE
   } sched_state_e;

   localparam int NUM_CH = 4;

   localparam logic [1:0] CH_R0_64 = 2'd0;
   localparam logic [1:0] CH_R1_64 = 2'd1;
   localparam logic [1:0] CH_R0_32 = 2'd2;
   localparam logic [1:0] CH_R1_32 = 2'd3;

   // Channels 0 and 1 carry 64-bit results and need two output words.
   function automatic logic is_64bit(input logic [1:0] ch);
      return (ch == CH_R0_64) || (ch == CH_R1_64);
   endfunction

endpackage

// File: rtl/lockin_result_scheduler_if.sv
// Merged 32-bit ready/valid result stream toward the processor FIFO.
interface lockin_result_scheduler_if;
   logic [31:0] fifo_data;
   logic        fifo_valid;
   logic        fifo_ready;

   modport master (output fifo_data, output fifo_valid, input fifo_ready);
   modport slave  (input fifo_data, input fifo_valid, output fifo_ready);
endinterface

// File: rtl/sched_result_slot.sv
// One-entry holding register for a result channel. Captures a sample when
// enabled; a sample arriving on a full slot is dropped and flagged, unless
// the slot is being drained in that same cycle.
module sched_result_slot #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             capture_en_i,
   input  logic             sample_valid_i,
   input  logic [WIDTH-1:0] sample_data_i,
   input  logic             drain_i,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o,
   output logic             ovf_o
);

   logic             full_q;
   logic [WIDTH-1:0] data_q;
   logic             take;

   assign take   = capture_en_i && sample_valid_i;
   assign ovf_o  = take && full_q && !drain_i;
   assign full_o = full_q;
   assign data_o = data_q;

   // Slot occupancy and data; a drain frees room for a same-cycle capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (take && (!full_q || drain_i)) begin
         full_q <= 1'b1;
         data_q <= sample_data_i;
      end else if (drain_i) begin
         full_q <= 1'b0;
      end
   end

endmodule

// File: rtl/lockin_result_scheduler.sv
// Lock-in run sequencer and result serialiser: resets and enables the
// datapath, then merges four result channels round-robin onto one 32-bit
// ready/valid stream. Optional watchdog: define LOCKIN_SCHED_WATCHDOG_EN.
module lockin_result_scheduler
   import lockin_sched_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 4
`ifdef LOCKIN_SCHED_WATCHDOG_EN
  ,parameter int unsigned WATCHDOG_CYCLES = 32'd16777216
`endif
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        calculo_finalizado,
   output logic        reset_op,
   output logic        enable,
   input  logic [63:0] result_0_64_bit,
   input  logic        result_0_64_bit_valid,
   input  logic [63:0] result_1_64_bit,
   input  logic        result_1_64_bit_valid,
   input  logic [31:0] result_0_32_bit,
   input  logic        result_0_32_bit_valid,
   input  logic [31:0] result_1_32_bit,
   input  logic        result_1_32_bit_valid,
   lockin_result_scheduler_if.master fifo,
   output logic        busy,
   output logic        done,
   output logic        overflow
`ifdef LOCKIN_SCHED_WATCHDOG_EN
  ,output logic        timeout
`endif
);

   localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

   sched_state_e state_q;
   logic [7:0]   rst_cnt_q;
   logic         reset_op_q, enable_q, busy_q, done_q, overflow_q;
   logic         start_acc, capture_en;

   logic [NUM_CH-1:0]        slot_full, slot_ovf, slot_drain;
   logic [63:0]              d0, d1;
   logic [31:0]              d2, d3;
   logic [NUM_CH-1:0][31:0]  lo_w;
   logic [1:0][31:0]         hi_w;

   logic [1:0]  ptr_q, lock_ch_q, sel_ch;
   logic        half_q, sel_vld, load_ok, load, last_word;
   logic [31:0] sel_word, fifo_data_q;
   logic        fifo_valid_q;

`ifdef LOCKIN_SCHED_WATCHDOG_EN
   localparam logic [31:0] WD_LAST = 32'(WATCHDOG_CYCLES - 1);
   logic [31:0] wd_cnt_q;
   logic        timeout_q;
   assign timeout = timeout_q;
`endif

   assign start_acc  = (state_q == IDLE) && start;
   assign capture_en = (state_q == RUN);

   // Run sequencer with registered control outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rst_cnt_q  <= '0;
         reset_op_q <= 1'b0;
         enable_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef LOCKIN_SCHED_WATCHDOG_EN
         wd_cnt_q   <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q    <= RESET;
               rst_cnt_q  <= '0;
               reset_op_q <= 1'b1;
               busy_q     <= 1'b1;
`ifdef LOCKIN_SCHED_WATCHDOG_EN
               timeout_q  <= 1'b0;
`endif
            end
            RESET: begin
               rst_cnt_q <= rst_cnt_q + 8'd1;
               if (rst_cnt_q == RST_LAST) begin
                  state_q    <= RUN;
                  reset_op_q <= 1'b0;
                  enable_q   <= 1'b1;
`ifdef LOCKIN_SCHED_WATCHDOG_EN
                  wd_cnt_q   <= '0;
`endif
               end
            end
            RUN: begin
               if (calculo_finalizado) begin
                  state_q  <= DRAIN;
                  enable_q <= 1'b0;
               end
`ifdef LOCKIN_SCHED_WATCHDOG_EN
               else if (wd_cnt_q == WD_LAST) begin
                  state_q   <= DRAIN;
                  enable_q  <= 1'b0;
                  timeout_q <= 1'b1;
               end else begin
                  wd_cnt_q <= wd_cnt_q + 32'd1;
               end
`endif
            end
            DRAIN: if (slot_full == '0 && !fifo_valid_q) begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   sched_result_slot #(.WIDTH(64)) u_slot_r0_64 (
      .clk(clk), .reset_n(reset_n), .capture_en_i(capture_en),
      .sample_valid_i(result_0_64_bit_valid), .sample_data_i(result_0_64_bit),
      .drain_i(slot_drain[CH_R0_64]), .full_o(slot_full[CH_R0_64]),
      .data_o(d0), .ovf_o(slot_ovf[CH_R0_64]));

   sched_result_slot #(.WIDTH(64)) u_slot_r1_64 (
      .clk(clk), .reset_n(reset_n), .capture_en_i(capture_en),
      .sample_valid_i(result_1_64_bit_valid), .sample_data_i(result_1_64_bit),
      .drain_i(slot_drain[CH_R1_64]), .full_o(slot_full[CH_R1_64]),
      .data_o(d1), .ovf_o(slot_ovf[CH_R1_64]));

   sched_result_slot #(.WIDTH(32)) u_slot_r0_32 (
      .clk(clk), .reset_n(reset_n), .capture_en_i(capture_en),
      .sample_valid_i(result_0_32_bit_valid), .sample_data_i(result_0_32_bit),
      .drain_i(slot_drain[CH_R0_32]), .full_o(slot_full[CH_R0_32]),
      .data_o(d2), .ovf_o(slot_ovf[CH_R0_32]));

   sched_result_slot #(.WIDTH(32)) u_slot_r1_32 (
      .clk(clk), .reset_n(reset_n), .capture_en_i(capture_en),
      .sample_valid_i(result_1_32_bit_valid), .sample_data_i(result_1_32_bit),
      .drain_i(slot_drain[CH_R1_32]), .full_o(slot_full[CH_R1_32]),
      .data_o(d3), .ovf_o(slot_ovf[CH_R1_32]));

   assign lo_w = {d3, d2, d1[31:0], d0[31:0]};
   assign hi_w = {d1[63:32], d0[63:32]};

   // Arbiter: finish a pending upper half first, else round-robin from ptr.
   always_comb begin
      logic [1:0] idx;
      idx     = '0;
      sel_vld = 1'b0;
      sel_ch  = '0;
      if (half_q) begin
         sel_vld = 1'b1;
         sel_ch  = lock_ch_q;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr_q + 2'(i);
            if (!sel_vld && slot_full[idx]) begin
               sel_vld = 1'b1;
               sel_ch  = idx;
            end
         end
      end
   end

   assign sel_word  = half_q ? hi_w[lock_ch_q[0]] : lo_w[sel_ch];
   assign load_ok   = !fifo_valid_q || fifo.fifo_ready;
   assign load      = load_ok && sel_vld;
   assign last_word = half_q || !is_64bit(sel_ch);

   // A slot is freed once its last word moves into the output register.
   always_comb begin
      slot_drain = '0;
      for (int c = 0; c < NUM_CH; c++)
         slot_drain[c] = load && last_word && (sel_ch == 2'(c));
   end

   // Output register, 64-bit split tracking and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifo_valid_q <= 1'b0;
         fifo_data_q  <= '0;
         half_q       <= 1'b0;
         lock_ch_q    <= '0;
         ptr_q        <= '0;
      end else begin
         if (load_ok) begin
            fifo_valid_q <= sel_vld;
            if (sel_vld)
               fifo_data_q <= sel_word;
         end
         if (load) begin
            half_q <= !last_word;
            if (!half_q) begin
               lock_ch_q <= sel_ch;
               ptr_q     <= sel_ch + 2'd1;
            end
         end
         if (start_acc)
            ptr_q <= '0;
      end
   end

   // Sticky drop flag, cleared by an accepted start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         overflow_q <= 1'b0;
      else if (start_acc)
         overflow_q <= 1'b0;
      else if (slot_ovf != '0)
         overflow_q <= 1'b1;
   end

   assign fifo.fifo_valid = fifo_valid_q;
   assign fifo.fifo_data  = fifo_data_q;
   assign reset_op        = reset_op_q;
   assign enable          = enable_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign overflow        = overflow_q;

endmodule

// File: tb/tb_lockin_result_scheduler.sv
// Scoreboard bench: stimulus pushes expected words, monitor pops on handshake.
module tb_lockin_result_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        calculo_finalizado = 1'b0;
   logic        reset_op, enable, busy, done, overflow;
   logic [63:0] r0_64 = '0, r1_64 = '0;
   logic [31:0] r0_32 = '0, r1_32 = '0;
   logic        r0_64_v = 1'b0, r1_64_v = 1'b0, r0_32_v = 1'b0, r1_32_v = 1'b0;
`ifdef LOCKIN_SCHED_WATCHDOG_EN
   logic        timeout;
`endif

   int errors = 0;
   int checks = 0;
   logic [31:0] sb[$];

   lockin_result_scheduler_if fifo_if ();

   lockin_result_scheduler #(
      .RESET_CYCLES(4)
`ifdef LOCKIN_SCHED_WATCHDOG_EN
     ,.WATCHDOG_CYCLES(50)
`endif
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .calculo_finalizado(calculo_finalizado),
      .reset_op(reset_op), .enable(enable),
      .result_0_64_bit(r0_64), .result_0_64_bit_valid(r0_64_v),
      .result_1_64_bit(r1_64), .result_1_64_bit_valid(r1_64_v),
      .result_0_32_bit(r0_32), .result_0_32_bit_valid(r0_32_v),
      .result_1_32_bit(r1_32), .result_1_32_bit_valid(r1_32_v),
      .fifo(fifo_if.master),
      .busy(busy), .done(done), .overflow(overflow)
`ifdef LOCKIN_SCHED_WATCHDOG_EN
     ,.timeout(timeout)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: hold-stability under backpressure and ordered word checking.
   initial begin
      logic        stall;
      logic [31:0] stall_data;
      stall = 1'b0;
      stall_data = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("hold_valid", 64'(fifo_if.fifo_valid), 64'd1);
               chk("hold_data", 64'(fifo_if.fifo_data), 64'(stall_data));
            end
            if (fifo_if.fifo_valid && fifo_if.fifo_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %h expected none", fifo_if.fifo_data);
               end else begin
                  chk("word", 64'(fifo_if.fifo_data), 64'(sb.pop_front()));
               end
            end
            stall = fifo_if.fifo_valid && !fifo_if.fifo_ready;
            stall_data = fifo_if.fifo_data;
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 200) begin
         step();
         n++;
      end
      chk("done_pulse", 64'(done), 64'd1);
      chk("busy_in_done", 64'(busy), 64'd0);
      step();
      chk("done_one_cycle", 64'(done), 64'd0);
   endtask

   initial begin
      int n;
      fifo_if.fifo_ready = 1'b0;
      #3;
      chk("rst_reset_op", 64'(reset_op), 64'd0);
      chk("rst_enable", 64'(enable), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_fifo_valid", 64'(fifo_if.fifo_valid), 64'd0);
      chk("rst_fifo_data", 64'(fifo_if.fifo_data), 64'd0);
      step();
      step();
      reset_n = 1'b1;
      step();

      // Basic sequence: reset_op held exactly 4 cycles, then enable.
      do_start();
      chk("busy_after_start", 64'(busy), 64'd1);
      n = 0;
      while (reset_op && n < 20) begin
         n++;
         step();
      end
      chk("reset_op_len", 64'(n), 64'd4);
      chk("enable_after_reset", 64'(enable), 64'd1);

      // Serialisation: ch0 and ch2 together, ready high.
      fifo_if.fifo_ready = 1'b1;
      r0_64 = 64'h1122334455667788; r0_64_v = 1'b1;
      r0_32 = 32'hAABBCCDD;         r0_32_v = 1'b1;
      sb.push_back(32'h55667788);
      sb.push_back(32'h11223344);
      sb.push_back(32'hAABBCCDD);
      step();
      r0_64_v = 1'b0; r0_32_v = 1'b0;
      step();
      chk("ser_w0", 64'(fifo_if.fifo_data), 64'h55667788);
      step();
      chk("ser_w1", 64'(fifo_if.fifo_data), 64'h11223344);
      step();
      chk("ser_w2", 64'(fifo_if.fifo_data), 64'hAABBCCDD);
      step();
      chk("ser_idle", 64'(fifo_if.fifo_valid), 64'd0);

      // Backpressure: ten stalled cycles with a 64-bit word pending.
      fifo_if.fifo_ready = 1'b0;
      r1_64 = 64'hDEADBEEFCAFEF00D; r1_64_v = 1'b1;
      sb.push_back(32'hCAFEF00D);
      sb.push_back(32'hDEADBEEF);
      step();
      r1_64_v = 1'b0;
      step();
      repeat (10) step();
      chk("bp_valid_held", 64'(fifo_if.fifo_valid), 64'd1);
      fifo_if.fifo_ready = 1'b1;
      repeat (3) step();

      // Overflow: output blocked, ch3 valid twice in a row.
      fifo_if.fifo_ready = 1'b0;
      r0_32 = 32'h00000022; r0_32_v = 1'b1;
      sb.push_back(32'h00000022);
      step();
      r0_32_v = 1'b0;
      step();
      r1_32 = 32'h33333333; r1_32_v = 1'b1;
      sb.push_back(32'h33333333);
      step();
      chk("ovf_not_yet", 64'(overflow), 64'd0);
      r1_32 = 32'h44444444;
      step();
      r1_32_v = 1'b0;
      chk("ovf_set", 64'(overflow), 64'd1);
      fifo_if.fifo_ready = 1'b1;
      repeat (4) step();

      // Fairness: all channels valid for six cycles, pointer at channel 0.
      r0_64 = 64'hA1A1A1A1A0A0A0A0; r1_64 = 64'hB1B1B1B1B0B0B0B0;
      r0_32 = 32'hC0C0C0C0;         r1_32 = 32'hD0D0D0D0;
      r0_64_v = 1'b1; r1_64_v = 1'b1; r0_32_v = 1'b1; r1_32_v = 1'b1;
      sb.push_back(32'hA0A0A0A0); sb.push_back(32'hA1A1A1A1);
      sb.push_back(32'hB0B0B0B0); sb.push_back(32'hB1B1B1B1);
      sb.push_back(32'hC0C0C0C0); sb.push_back(32'hD0D0D0D0);
      sb.push_back(32'hA0A0A0A0); sb.push_back(32'hA1A1A1A1);
      sb.push_back(32'hB0B0B0B0); sb.push_back(32'hB1B1B1B1);
      sb.push_back(32'hC0C0C0C0);
      repeat (6) step();
      r0_64_v = 1'b0; r1_64_v = 1'b0; r0_32_v = 1'b0; r1_32_v = 1'b0;
      repeat (15) step();
      chk("fair_drained", 64'(sb.size()), 64'd0);

      // Finish: a sample in the calculo_finalizado cycle is still captured.
      calculo_finalizado = 1'b1;
      r1_32 = 32'h55550000; r1_32_v = 1'b1;
      sb.push_back(32'h55550000);
      step();
      calculo_finalizado = 1'b0; r1_32_v = 1'b0;
      chk("enable_low_drain", 64'(enable), 64'd0);
      chk("busy_drain", 64'(busy), 64'd1);
      wait_done();
      chk("sb_empty_run1", 64'(sb.size()), 64'd0);

      // Next start clears overflow.
      do_start();
      chk("ovf_cleared", 64'(overflow), 64'd0);
      repeat (4) step();
      chk("run2_enable", 64'(enable), 64'd1);

      // Async reset mid-DRAIN with two slots occupied.
      fifo_if.fifo_ready = 1'b0;
      r0_64 = 64'h0123456789ABCDEF; r0_64_v = 1'b1;
      r0_32 = 32'h0BADF00D;         r0_32_v = 1'b1;
      calculo_finalizado = 1'b1;
      step();
      r0_64_v = 1'b0; r0_32_v = 1'b0; calculo_finalizado = 1'b0;
      step();
      chk("pre_rst_data", 64'(fifo_if.fifo_data), 64'h89ABCDEF);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_fifo_valid", 64'(fifo_if.fifo_valid), 64'd0);
      chk("arst_fifo_data", 64'(fifo_if.fifo_data), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_enable", 64'(enable), 64'd0);
      chk("arst_reset_op", 64'(reset_op), 64'd0);
      sb.delete();
      step();
      reset_n = 1'b1;
      fifo_if.fifo_ready = 1'b1;
      step();
      chk("idle_busy", 64'(busy), 64'd0);
      do_start();
      chk("restart_reset_op", 64'(reset_op), 64'd1);
      n = 0;
      while (!enable && n < 20) begin
         step();
         n++;
      end
      chk("run3_enable", 64'(enable), 64'd1);
`ifdef LOCKIN_SCHED_WATCHDOG_EN
      chk("timeout_clear", 64'(timeout), 64'd0);
      n = 0;
      while (!timeout && n < 200) begin
         step();
         n++;
      end
      chk("timeout_set", 64'(timeout), 64'd1);
      chk("timeout_enable_low", 64'(enable), 64'd0);
`else
      repeat (3) step();
      calculo_finalizado = 1'b1;
      step();
      calculo_finalizado = 1'b0;
`endif
      wait_done();
      chk("final_overflow", 64'(overflow), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lockin_result_scheduler.md
# lockin_result_scheduler

Sequences one lock-in acquisition run and serialises its results toward the processor. On a start command it resets the datapath, enables it until `calculo_finalizado`, then drains the results. The two 64-bit and two 32-bit result channels are merged by a round-robin arbiter onto a single 32-bit ready/valid stream feeding one processor FIFO. It sits between the processing datapath and the processor-side FIFO/register interface, replacing per-channel FIFOs.

## Interface
- `RESET_CYCLES`, 4: number of cycles `reset_op` is held high at run start; legal range 1–255.
- `clk` in 1: system clock, all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle run request from the processor register.
- `calculo_finalizado` in 1: datapath finished.
- `reset_op` out 1: datapath reset pulse.
- `enable` out 1: datapath enable.
- `result_0_64_bit` in 64, `result_0_64_bit_valid` in 1: channel 0.
- `result_1_64_bit` in 64, `result_1_64_bit_valid` in 1: channel 1.
- `result_0_32_bit` in 32, `result_0_32_bit_valid` in 1: channel 2.
- `result_1_32_bit` in 32, `result_1_32_bit_valid` in 1: channel 3.
- `fifo_data` out 32, `fifo_valid` out 1, `fifo_ready` in 1: merged output stream.
- `busy` out 1: high in RESET, RUN and DRAIN.
- `done` out 1: one-cycle pulse at end of run.
- `overflow` out 1: sticky; a sample was dropped.

## Operation
- FSM states and transitions:
  - IDLE → RESET on `start`.
  - RESET → RUN after `RESET_CYCLES` cycles.
  - RUN → DRAIN on `calculo_finalizado`.
  - DRAIN → DONE when all slots are empty and `fifo_valid` is low.
  - DONE → IDLE unconditionally.
- `start` is ignored outside IDLE. Accepting `start` clears `overflow` and the arbiter pointer.
- `reset_op` is high only in RESET. `enable` is high only in RUN.
- Each channel has a one-entry slot. A valid sample is captured only in RUN, including the cycle in which `calculo_finalizado` is high.
- Valid sample on a full slot: the sample is dropped, the slot keeps its old data, and `overflow` is set.
  - Exception: if the slot's last word is accepted downstream in the same cycle, the new sample is captured and there is no overflow.
- Arbiter is round-robin over channels 0,1,2,3.
  - After a channel is granted, the pointer moves to the next channel (granted channel + 1).
  - The search starts at the pointer.
- 64-bit channels emit two words atomically: `[31:0]` first, then `[63:32]`. No other channel can be granted between the two halves.
- Output register follows AXI-style rules:
  - `fifo_data` is stable while `fifo_valid && !fifo_ready`.
  - `fifo_valid` never drops without a handshake.
  - The output register reloads in the same cycle as a handshake.
- Asynchronous reset at any point: FSM to IDLE, all slots emptied, all outputs 0. Words in flight are lost.

## Timing
- Reset values of all outputs: `reset_op`, `enable`, `fifo_valid`, `busy`, `done`, `overflow` = 0; `fifo_data` = 0.
- `start` sampled at edge k: `reset_op` and `busy` go high after edge k, for exactly `RESET_CYCLES` cycles. `enable` rises on the cycle following the last `reset_op` cycle.
- `calculo_finalizado` sampled at edge k in RUN: `enable` is low after edge k.
- Sample captured at edge k with output idle: the first word is valid after edge k+1.
- Throughput with `fifo_ready` held high: one word per cycle. A 64-bit sample occupies 2 cycles.
- DONE lasts one cycle. `busy` is low in DONE. `start` is accepted from the following IDLE cycle.

## Configuration
- Macro `LOCKIN_SCHED_WATCHDOG_EN`.
- Defined:
  - Adds parameter `WATCHDOG_CYCLES` (default 2^24) and output `timeout` (1 bit, sticky, reset 0, cleared on accepted `start`).
  - If RUN lasts `WATCHDOG_CYCLES` cycles without `calculo_finalizado`, the FSM goes to DRAIN and sets `timeout`.
- Undefined: no counter and no port. RUN waits indefinitely.

## Structure
- Package `lockin_sched_pkg`:
  - FSM state enum (IDLE, RESET, RUN, DRAIN, DONE).
  - `NUM_CH` = 4.
  - Channel index constants `CH_R0_64`, `CH_R1_64`, `CH_R0_32`, `CH_R1_32`.
- Sub-module `sched_result_slot`: parameterised `WIDTH` one-entry holding register with capture/clear/overflow logic. Instantiated four times: twice with `WIDTH`=64, twice with `WIDTH`=32.

## Test plan
- Basic sequence: `RESET_CYCLES`=4, `start` pulse → `reset_op` high exactly 4 cycles, then `enable` high. `calculo_finalizado` → DRAIN → `done` pulse, `busy` low.
- Serialisation: during RUN, channel 0 = 64'h1122334455667788 and channel 2 = 32'hAABBCCDD valid in the same cycle, `fifo_ready`=1 → words 55667788, 11223344, AABBCCDD on consecutive cycles.
- Backpressure: `fifo_ready`=0 for 10 cycles with a word pending → `fifo_data` stable and `fifo_valid` held. Release → no loss, no duplication.
- Overflow: channel 3 valid two cycles in a row with `fifo_ready`=0 → second sample dropped, `overflow`=1. Next `start` clears it.
- Fairness: all four channels valid every cycle, `fifo_ready`=1 → grant order 0,1,2,3,0… and no 64-bit split is interleaved.
- Asynchronous reset asserted mid-DRAIN with 2 slots full → all outputs 0 immediately, IDLE after release. With the macro defined, no `calculo_finalizado` for `WATCHDOG_CYCLES` → `timeout`=1, then `done`.
